// File: rtl/sockit_spi_pkg.sv
// Shared types and constants for the SPI slave.
package sockit_spi_pkg;

  // Transfer state: waiting for select, fetching the first TX word, shifting bits.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  // Fewest synchronizer stages that still give a usable MTBF.
  localparam int SYN_MIN = 2;

endpackage

// File: rtl/sockit_spi_syn.sv
// Multi-stage synchronizer for a single asynchronous bit with a selectable reset level.
module sockit_spi_syn
  import sockit_spi_pkg::*;
#(
  parameter int   SYN     = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int N = (SYN < SYN_MIN) ? SYN_MIN : SYN;

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  // Shift the raw input in at the bottom of the chain.
  always_comb begin
    sr_d = {sr_q[N-2:0], d};
  end

  // Chain flops reset to the inactive level of the line they guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= {N{RST_VAL}};
    else      sr_q <= sr_d;
  end

  assign q = sr_q[N-1];

endmodule

// File: rtl/sockit_spi_slv.sv
// SPI slave running entirely in the clk domain. SCLK, SS_n and MOSI are oversampled
// through synchronizers, so each SCLK high and low phase must last at least SYN+2
// clk periods; faster SCLK is not detected and gives undefined results.
module sockit_spi_slv
  import sockit_spi_pkg::*;
#(
  parameter int          DW   = 8,
  parameter logic        CPOL = 1'b0,
  parameter logic        CPHA = 1'b0,
  parameter int          SYN  = 2,
  parameter logic [DW-1:0] IDL = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_sclk,
  input  logic          spi_ss_n,
  input  logic          spi_mosi,
  output logic          spi_miso_o,
  output logic          spi_miso_e,
  input  logic          tx_vld,
  input  logic [DW-1:0] tx_dat,
  output logic          tx_rdy,
  output logic          rx_vld,
  output logic [DW-1:0] rx_dat,
  input  logic          rx_rdy,
  output logic          sts_ovf,
  output logic          sts_unf,
  input  logic          sts_clr
);

  localparam int NS = (SYN < SYN_MIN) ? SYN_MIN : SYN;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int SW = $clog2(NS + 2) + 1;
  localparam logic [CW-1:0] LAST   = CW'(DW - 1);
  localparam logic [SW-1:0] SETTLE = SW'(NS + 1);

  logic sclk_s, ss_n_s, mosi_s;

  sockit_spi_syn #(.SYN(NS), .RST_VAL(CPOL)) u_syn_sclk (.clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
  sockit_spi_syn #(.SYN(NS), .RST_VAL(1'b1)) u_syn_ss_n (.clk(clk), .rst(rst), .d(spi_ss_n), .q(ss_n_s));
  sockit_spi_syn #(.SYN(NS), .RST_VAL(1'b0)) u_syn_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

  state_t          state_q, state_d;
  logic            sclk_prev_q, sclk_prev_d;
  logic            ss_n_prev_q, ss_n_prev_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   obit_q, obit_d;
  logic [DW-1:0]   rx_sr_q, rx_sr_d;
  logic            done_q, done_d;
  logic [DW-1:0]   tx_q, tx_d;
  logic            tx_rdy_q, tx_rdy_d;
  logic            rx_vld_q, rx_vld_d;
  logic [DW-1:0]   rx_dat_q, rx_dat_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            miso_e_q, miso_e_d;

  logic live, lead, trail, ss_fall, ss_rise, sample, shift, fetch, unf_set, ovf_set;

  // Edge detection, transfer FSM next state, TX fetch, RX hand-off and sticky flags.
  always_comb begin
    state_d     = state_q;
    sclk_prev_d = sclk_s;
    ss_n_prev_d = ss_n_s;
    bit_d       = bit_q;
    obit_d      = obit_q;
    rx_sr_d     = rx_sr_q;
    done_d      = 1'b0;
    tx_d        = tx_q;
    tx_rdy_d    = 1'b0;
    rx_vld_d    = rx_vld_q;
    rx_dat_d    = rx_dat_q;
    fetch       = 1'b0;
    unf_set     = 1'b0;
    ovf_set     = 1'b0;

    // Edges are ignored until the synchronizers have refilled after reset, so a
    // select held low through reset release is not mistaken for a new transfer.
    live     = (settle_q == SETTLE);
    settle_d = live ? settle_q : settle_q + 1'b1;

    lead    = live && (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    trail   = live && (sclk_prev_q != CPOL) && (sclk_s == CPOL);
    ss_fall = live && ss_n_prev_q && !ss_n_s;
    ss_rise = live && !ss_n_prev_q && ss_n_s;
    sample  = CPHA ? trail : lead;
    // With CPHA=1 the first leading edge of a word only launches bit 0, already on the line.
    shift   = CPHA ? (lead && (bit_q != '0)) : trail;

    case (state_q)
      ST_IDLE: begin
        bit_d   = '0;
        obit_d  = '0;
        rx_sr_d = '0;
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fetch   = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift) obit_d = (obit_q == LAST) ? '0 : obit_q + 1'b1;
        if (sample) begin
          rx_sr_d = (rx_sr_q << 1) | DW'(mosi_s);
          if (bit_q == LAST) begin
            bit_d  = '0;
            done_d = 1'b1;
            fetch  = 1'b1;
            if (CPHA) obit_d = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect aborts whatever is in flight; a partial word is simply forgotten.
    if (state_q != ST_IDLE && ss_rise) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      obit_d  = '0;
      rx_sr_d = '0;
      done_d  = 1'b0;
      fetch   = 1'b0;
    end

    if (fetch) begin
      if (tx_vld) begin
        tx_d     = tx_dat;
        tx_rdy_d = 1'b1;
      end else begin
        tx_d    = IDL;
        unf_set = 1'b1;
      end
    end

    // A word completing in the same cycle the consumer takes the old one is kept.
    if (done_q) begin
      if (!rx_vld_q || rx_rdy) begin
        rx_dat_d = rx_sr_q;
        rx_vld_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (rx_vld_q && rx_rdy) begin
      rx_vld_d = 1'b0;
    end

    ovf_d    = (ovf_q && !sts_clr) || ovf_set;
    unf_d    = (unf_q && !sts_clr) || unf_set;
    miso_e_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset returns to IDLE with outputs quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= CPOL;
      ss_n_prev_q <= 1'b1;
      settle_q    <= '0;
      bit_q       <= '0;
      obit_q      <= '0;
      rx_sr_q     <= '0;
      done_q      <= 1'b0;
      tx_q        <= '0;
      tx_rdy_q    <= 1'b0;
      rx_vld_q    <= 1'b0;
      rx_dat_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      miso_e_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      ss_n_prev_q <= ss_n_prev_d;
      settle_q    <= settle_d;
      bit_q       <= bit_d;
      obit_q      <= obit_d;
      rx_sr_q     <= rx_sr_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      tx_rdy_q    <= tx_rdy_d;
      rx_vld_q    <= rx_vld_d;
      rx_dat_q    <= rx_dat_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      miso_e_q    <= miso_e_d;
    end
  end

  assign spi_miso_o = tx_q[LAST - obit_q];
  assign spi_miso_e = miso_e_q;
  assign tx_rdy     = tx_rdy_q;
  assign rx_vld     = rx_vld_q;
  assign rx_dat     = rx_dat_q;
  assign sts_ovf    = ovf_q;
  assign sts_unf    = unf_q;

endmodule

// File: tb/tb_sockit_spi_slv.sv
// Bench for sockit_spi_slv: a mode-0 and a mode-3 instance driven by a bit-banged master.
module tb_sockit_spi_slv;

  localparam int SYN = 2;
  localparam int H   = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sts_clr;
  logic       sclk [2];
  logic       ss_n [2];
  logic       mosi [2];
  logic       miso_o [2];
  logic       miso_e [2];
  logic       tx_vld [2];
  logic [7:0] tx_dat [2];
  logic       tx_rdy [2];
  logic       rx_vld [2];
  logic [7:0] rx_dat [2];
  logic       rx_rdy [2];
  logic       sts_ovf [2];
  logic       sts_unf [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_mem [256];
  int         tx_wr = 0;
  int         tx_rd = 0;
  int         rdy_cnt [2];
  logic [7:0] got [$];
  logic       auto_rdy [2];
  logic       man_rdy [2];
  logic [7:0] mo_q [$];
  logic [7:0] mi_q [$];

  always #5 clk = ~clk;

  sockit_spi_slv #(.DW(8), .CPOL(1'b0), .CPHA(1'b0), .SYN(SYN), .IDL(8'hFF)) u_m0 (
    .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_ss_n(ss_n[0]), .spi_mosi(mosi[0]),
    .spi_miso_o(miso_o[0]), .spi_miso_e(miso_e[0]), .tx_vld(tx_vld[0]), .tx_dat(tx_dat[0]),
    .tx_rdy(tx_rdy[0]), .rx_vld(rx_vld[0]), .rx_dat(rx_dat[0]), .rx_rdy(rx_rdy[0]),
    .sts_ovf(sts_ovf[0]), .sts_unf(sts_unf[0]), .sts_clr(sts_clr));

  sockit_spi_slv #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .SYN(SYN), .IDL(8'hFF)) u_m3 (
    .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_ss_n(ss_n[1]), .spi_mosi(mosi[1]),
    .spi_miso_o(miso_o[1]), .spi_miso_e(miso_e[1]), .tx_vld(tx_vld[1]), .tx_dat(tx_dat[1]),
    .tx_rdy(tx_rdy[1]), .rx_vld(rx_vld[1]), .rx_dat(rx_dat[1]), .rx_rdy(rx_rdy[1]),
    .sts_ovf(sts_ovf[1]), .sts_unf(sts_unf[1]), .sts_clr(sts_clr));

  // Application side: TX word source from tx_mem, RX sink into got, tx_rdy counting.
  initial begin
    for (int m = 0; m < 2; m++) begin
      rx_rdy[m] = 1'b0; tx_vld[m] = 1'b0; tx_dat[m] = 8'h00; rdy_cnt[m] = 0;
    end
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (tx_rdy[m] === 1'b1) begin
          rdy_cnt[m] = rdy_cnt[m] + 1;
          if (tx_rd < tx_wr) tx_rd = tx_rd + 1;
        end
        if (auto_rdy[m]) begin
          if (rx_vld[m] === 1'b1 && rx_rdy[m] == 1'b0) begin
            got.push_back(rx_dat[m]);
            rx_rdy[m] = 1'b1;
          end else begin
            rx_rdy[m] = 1'b0;
          end
        end else begin
          rx_rdy[m] = man_rdy[m];
        end
      end
      for (int m = 0; m < 2; m++) begin
        tx_vld[m] = (tx_rd < tx_wr);
        tx_dat[m] = tx_mem[tx_rd % 256];
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] w);
    tx_mem[tx_wr % 256] = w;
    tx_wr = tx_wr + 1;
  endtask

  task automatic pulse_clr();
    sts_clr = 1'b1;
    wait_clk(1);
    sts_clr = 1'b0;
    wait_clk(1);
  endtask

  // Master: sends nbits from mo_q MSB first, collects full bytes read back into mi_q.
  task automatic spi_xfer(input int m, input int nbits, input bit raise);
    logic [7:0] w;
    logic [7:0] r;
    mi_q.delete();
    r = 8'h00;
    ss_n[m] = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      w = mo_q[i / 8];
      if (m == 0) begin
        mosi[m] = w[7 - (i % 8)];
        wait_clk(H);
        sclk[m] = 1'b1;
        r = {r[6:0], miso_o[m]};
        wait_clk(H);
        sclk[m] = 1'b0;
      end else begin
        sclk[m] = 1'b0;
        mosi[m] = w[7 - (i % 8)];
        wait_clk(H);
        sclk[m] = 1'b1;
        r = {r[6:0], miso_o[m]};
        wait_clk(H);
      end
      if (i % 8 == 7) mi_q.push_back(r);
    end
    if (raise) begin
      wait_clk(H);
      ss_n[m] = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clk(3);
    for (int m = 0; m < 2; m++) begin
      n_tests++; if ({miso_e[m], miso_o[m], tx_rdy[m], rx_vld[m], sts_ovf[m], sts_unf[m], rx_dat[m]} !== 14'h0) begin n_fail++; $display("FAIL reset_outputs[%0d] got=%h exp=0", m, {miso_e[m], miso_o[m], tx_rdy[m], rx_vld[m], sts_ovf[m], sts_unf[m], rx_dat[m]}); end
    end
    rst = 1'b1;
    wait_clk(10);
    for (int m = 0; m < 2; m++) begin
      n_tests++; if (miso_e[m] !== 1'b0) begin n_fail++; $display("FAIL idle_miso_e[%0d] got=%b exp=0", m, miso_e[m]); end
    end
  endtask

  task automatic test_mode0();
    int b = got.size();
    int r0 = rdy_cnt[0];
    pulse_clr();
    push_tx(8'hA5);
    mo_q.delete(); mo_q.push_back(8'h3C);
    spi_xfer(0, 8, 1'b1);
    n_tests++; if (got.size() - b !== 1) begin n_fail++; $display("FAIL mode0_rx_count got=%0d exp=1", got.size() - b); end
    n_tests++; if (got.size() > b && got[b] !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx got=%h exp=3c", got[b]); end
    n_tests++; if (mi_q[0] !== 8'hA5) begin n_fail++; $display("FAIL mode0_miso got=%h exp=a5", mi_q[0]); end
    n_tests++; if (rdy_cnt[0] - r0 !== 1) begin n_fail++; $display("FAIL mode0_tx_rdy got=%0d exp=1", rdy_cnt[0] - r0); end
  endtask

  task automatic test_back_to_back();
    int b = got.size();
    int r0 = rdy_cnt[1];
    push_tx(8'h12); push_tx(8'h34);
    mo_q.delete(); mo_q.push_back(8'h81); mo_q.push_back(8'h7E);
    spi_xfer(1, 16, 1'b1);
    n_tests++; if (got.size() - b !== 2) begin n_fail++; $display("FAIL mode3_rx_count got=%0d exp=2", got.size() - b); end
    n_tests++; if (got.size() > b + 1 && {got[b], got[b+1]} !== 16'h817E) begin n_fail++; $display("FAIL mode3_rx got=%h%h exp=817e", got[b], got[b+1]); end
    n_tests++; if ({mi_q[0], mi_q[1]} !== 16'h1234) begin n_fail++; $display("FAIL mode3_miso got=%h%h exp=1234", mi_q[0], mi_q[1]); end
    n_tests++; if (rdy_cnt[1] - r0 !== 2) begin n_fail++; $display("FAIL mode3_tx_rdy got=%0d exp=2", rdy_cnt[1] - r0); end
  endtask

  task automatic test_underrun();
    int r0 = rdy_cnt[0];
    pulse_clr();
    n_tests++; if (sts_unf[0] !== 1'b0) begin n_fail++; $display("FAIL unf_cleared_before got=%b exp=0", sts_unf[0]); end
    mo_q.delete(); mo_q.push_back(8'h5A);
    spi_xfer(0, 8, 1'b1);
    n_tests++; if (mi_q[0] !== 8'hFF) begin n_fail++; $display("FAIL unf_miso got=%h exp=ff", mi_q[0]); end
    wait_clk(20);
    n_tests++; if (sts_unf[0] !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%b exp=1", sts_unf[0]); end
    n_tests++; if (rdy_cnt[0] - r0 !== 0) begin n_fail++; $display("FAIL unf_tx_rdy got=%0d exp=0", rdy_cnt[0] - r0); end
    pulse_clr();
    n_tests++; if (sts_unf[0] !== 1'b0) begin n_fail++; $display("FAIL unf_clear got=%b exp=0", sts_unf[0]); end
  endtask

  task automatic test_overflow();
    pulse_clr();
    auto_rdy[0] = 1'b0;
    mo_q.delete(); mo_q.push_back(8'h11); mo_q.push_back(8'h22);
    spi_xfer(0, 16, 1'b1);
    n_tests++; if (rx_vld[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_rx_vld got=%b exp=1", rx_vld[0]); end
    n_tests++; if (rx_dat[0] !== 8'h11) begin n_fail++; $display("FAIL ovf_rx_dat got=%h exp=11", rx_dat[0]); end
    n_tests++; if (sts_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", sts_ovf[0]); end
    man_rdy[0] = 1'b1;
    wait_clk(3);
    man_rdy[0] = 1'b0;
    wait_clk(2);
    n_tests++; if (rx_vld[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy_clears got=%b exp=0", rx_vld[0]); end
    auto_rdy[0] = 1'b1;
    pulse_clr();
    n_tests++; if (sts_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", sts_ovf[0]); end
  endtask

  task automatic test_abort();
    int b = got.size();
    int cyc = 0;
    pulse_clr();
    push_tx(8'h9C);
    mo_q.delete(); mo_q.push_back(8'hB7);
    spi_xfer(0, 5, 1'b0);
    ss_n[0] = 1'b1;
    while (miso_e[0] !== 1'b0 && cyc < SYN + 2) begin wait_clk(1); cyc++; end
    n_tests++; if (miso_e[0] !== 1'b0) begin n_fail++; $display("FAIL abort_miso_e got=%b exp=0 after %0d cycles", miso_e[0], cyc); end
    wait_clk(20);
    n_tests++; if (got.size() - b !== 0) begin n_fail++; $display("FAIL abort_no_rx got=%0d exp=0", got.size() - b); end
    n_tests++; if ({sts_ovf[0], sts_unf[0]} !== 2'b00) begin n_fail++; $display("FAIL abort_flags got=%b exp=00", {sts_ovf[0], sts_unf[0]}); end
    push_tx(8'hAA);
    mo_q.delete(); mo_q.push_back(8'h55);
    spi_xfer(0, 8, 1'b1);
    n_tests++; if (got.size() - b !== 1 || got[b] !== 8'h55) begin n_fail++; $display("FAIL abort_next_rx count=%0d exp=1, value exp=55", got.size() - b); end
    n_tests++; if (mi_q[0] !== 8'hAA) begin n_fail++; $display("FAIL abort_next_miso got=%h exp=aa", mi_q[0]); end
  endtask

  task automatic test_reset_mid();
    int b;
    auto_rdy[0] = 1'b0;
    mo_q.delete(); mo_q.push_back(8'h5A);
    spi_xfer(0, 8, 1'b1);
    spi_xfer(0, 4, 1'b0);
    n_tests++; if ({rx_vld[0], sts_unf[0], miso_e[0]} !== 3'b111) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=111", {rx_vld[0], sts_unf[0], miso_e[0]}); end
    rst = 1'b0;
    #1;
    n_tests++; if ({miso_e[0], miso_o[0], tx_rdy[0], rx_vld[0], sts_ovf[0], sts_unf[0], rx_dat[0]} !== 14'h0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", {miso_e[0], miso_o[0], tx_rdy[0], rx_vld[0], sts_ovf[0], sts_unf[0], rx_dat[0]}); end
    ss_n[0] = 1'b1; sclk[0] = 1'b0; mosi[0] = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    auto_rdy[0] = 1'b1;
    wait_clk(6);
    b = got.size();
    push_tx(8'hD2);
    mo_q.delete(); mo_q.push_back(8'hC3);
    spi_xfer(0, 8, 1'b1);
    n_tests++; if (got.size() - b !== 1 || got[b] !== 8'hC3) begin n_fail++; $display("FAIL rstmid_rx count=%0d exp=1, value exp=c3", got.size() - b); end
    n_tests++; if (mi_q[0] !== 8'hD2) begin n_fail++; $display("FAIL rstmid_miso got=%h exp=d2", mi_q[0]); end
  endtask

  // Random transfers: RX must echo the master, MISO follows supplied words then IDL.
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int m = $urandom_range(0, 1);
      int n = $urandom_range(1, 3);
      int k = $urandom_range(0, n);
      int b = got.size();
      int r0 = rdy_cnt[m];
      logic [7:0] tw [4];
      pulse_clr();
      mo_q.delete();
      for (int j = 0; j < n; j++) mo_q.push_back(8'($urandom));
      for (int j = 0; j < k; j++) begin tw[j] = 8'($urandom); push_tx(tw[j]); end
      spi_xfer(m, 8 * n, 1'b1);
      n_tests++; if (got.size() - b !== n) begin n_fail++; $display("FAIL rand%0d_rx_count got=%0d exp=%0d", it, got.size() - b, n); end
      for (int j = 0; j < n; j++) begin
        logic [7:0] exp_mi;
        exp_mi = (j < k) ? tw[j] : 8'hFF;
        n_tests++; if (got.size() > b + j && got[b+j] !== mo_q[j]) begin n_fail++; $display("FAIL rand%0d_rx[%0d] got=%h exp=%h", it, j, got[b+j], mo_q[j]); end
        n_tests++; if (mi_q[j] !== exp_mi) begin n_fail++; $display("FAIL rand%0d_miso[%0d] got=%h exp=%h", it, j, mi_q[j], exp_mi); end
      end
      n_tests++; if (rdy_cnt[m] - r0 !== k) begin n_fail++; $display("FAIL rand%0d_tx_rdy got=%0d exp=%0d", it, rdy_cnt[m] - r0, k); end
      n_tests++; if ({sts_ovf[m], sts_unf[m]} !== 2'b01) begin n_fail++; $display("FAIL rand%0d_flags got=%b exp=01", it, {sts_ovf[m], sts_unf[m]}); end
    end
  endtask

  initial begin
    rst = 1'b0;
    sts_clr = 1'b0;
    sclk[0] = 1'b0; sclk[1] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      ss_n[m] = 1'b1; mosi[m] = 1'b0; auto_rdy[m] = 1'b1; man_rdy[m] = 1'b0;
    end
    test_reset();
    test_mode0();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sockit_spi_slv.md
SOCKIT_SPI_SLV -- requirements
Module: sockit_spi_slv

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the SPI word width in bits.
REQ-002 The block SHALL have parameter CPOL, default 1'b0, giving the SCLK idle level.
REQ-003 The block SHALL have parameter CPHA, default 1'b0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 The block SHALL have parameter SYN, default 2, giving the number of synchronizer flops (minimum 2).
REQ-005 The block SHALL have parameter IDL, default all ones, giving the MISO word sent on TX underrun.
REQ-006 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single system clock; all logic is clocked on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock from the master, asynchronous to clk.
- spi_ss_n  in  1  slave select, active low, asynchronous.
- spi_mosi  in  1  serial data from the master.
- spi_miso_o  out  1  serial data to the master.
- spi_miso_e  out  1  MISO output enable.
- tx_vld  in  1  TX word valid.
- tx_dat  in  DW  TX word.
- tx_rdy  out  1  TX word accepted (one-cycle pulse).
- rx_vld  out  1  RX word valid.
- rx_dat  out  DW  RX word.
- rx_rdy  in  1  RX word consumed.
- sts_ovf  out  1  sticky RX overflow flag.
- sts_unf  out  1  sticky TX underrun flag.
- sts_clr  in  1  clears both sticky flags.

Function
REQ-007 spi_sclk, spi_ss_n and spi_mosi SHALL each pass through SYN flops; all decisions SHALL use the synchronized values only.
REQ-008 Edges SHALL be detected by comparing each synchronized signal with its previous registered value; a leading edge is SCLK leaving CPOL, a trailing edge is SCLK returning to CPOL.
REQ-009 The FSM SHALL have three states:
- IDLE to LOAD on synchronized ss_n falling.
- LOAD to SHIFT after one cycle.
- SHIFT to IDLE on synchronized ss_n rising, from any state except IDLE.
REQ-010 In LOAD, and at every word boundary, if tx_vld=1 the TX register SHALL take tx_dat and pulse tx_rdy for one cycle; otherwise it SHALL take IDL and set sts_unf.
REQ-011 spi_miso_e SHALL be 1 in LOAD and SHIFT and 0 in IDLE; spi_miso_o SHALL be bit (DW-1-obit) of the TX register, MSB first.
REQ-012 obit SHALL increment on every shift edge (trailing when CPHA=0, leading when CPHA=1), except that the first leading edge of each word with CPHA=1 SHALL NOT increment it.
REQ-013 On each sample edge, synchronized MOSI SHALL shift into the RX shift register at the LSB, and the bit counter SHALL increment modulo DW.
REQ-014 On the DW-th sample edge:
- if rx_vld=0, rx_dat SHALL be loaded and rx_vld set on the next clk edge, which is the (SYN+2)th clk rising edge after the raw SCLK edge;
- if rx_vld=1, the new word SHALL be dropped and sts_ovf set.
REQ-015 rx_vld SHALL clear in the cycle after rx_vld=1 and rx_rdy=1; a simultaneous word completion in that same cycle SHALL be stored, not flagged as overflow.
REQ-016 The next TX word SHALL be fetched per REQ-010 on the DW-th sample edge, so it is on spi_miso_o before the next word's first shift or sample edge.
REQ-017 ss_n deassertion mid-word SHALL discard the partial RX word, reset the counters, and produce no rx_vld and no flag.
REQ-018 sts_clr SHALL clear both flags; a set event in the same cycle as sts_clr SHALL win.
REQ-019 Correct operation SHALL be guaranteed only when SCLK high and low phases are each at least SYN+2 clk periods; this SHALL be documented, not checked.

Reset
REQ-020 On rst=0 the block SHALL asynchronously enter IDLE and force spi_miso_e=0, spi_miso_o=0, tx_rdy=0, rx_vld=0, rx_dat=0, sts_ovf=0 and sts_unf=0, and clear all counters.
REQ-021 The synchronizers SHALL reset to the inactive levels: sclk=CPOL, ss_n=1, mosi=0.
REQ-022 Reset during a transfer SHALL abort it; after release the block SHALL wait for a fresh ss_n falling edge.

Structure
REQ-023 The FSM state enum and a synchronizer-depth constant SHALL be placed in sockit_spi_pkg.
REQ-024 The block SHALL contain one sub-module, sockit_spi_syn, a parameterized SYN-stage synchronizer with a reset value, instanced three times.
REQ-025 The block SHALL contain no clock-domain logic other than these synchronizers.

Verification
REQ-026 Mode 0 (CPOL=0, CPHA=0), tx_dat=8'hA5 preloaded, master sends 8'h3C: rx_dat=8'h3C with a single rx_vld; the master receives 8'hA5; tx_rdy pulses once.
REQ-027 Mode 3 (CPOL=1, CPHA=1), two back-to-back words 8'h81 and 8'h7E, with TX words 8'h12 and 8'h34 supplied: both received in order; the master reads 8'h12 then 8'h34.
REQ-028 tx_vld=0 throughout a word: the master reads 8'hFF; sts_unf=1 until sts_clr; tx_rdy never pulses.
REQ-029 rx_rdy=0 while two words 8'h11 and 8'h22 arrive: rx_dat=8'h11; sts_ovf=1; rx_rdy then clears rx_vld.
REQ-030 ss_n raised after 5 bits: no rx_vld; spi_miso_e=0 within SYN+2 cycles; the next full word 8'h55 is received correctly.
REQ-031 rst asserted mid-word: all outputs go to their reset values immediately; a post-release word 8'hC3 is received correctly.
